alu_exec_stage: RTL and testbench

Execute-stage datapath block that sits directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code together with two operands and a destination tag. It computes add/sub/and/or and buffers results in a 2-entry output queue behind a valid/ready handshake. The `zero` flag it produces drives branch resolution (beq) and the result feeds memory-address (ld/sd) and writeback paths.

---
 rtl/alu_exec_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_exec_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Execute-stage datapath: computes add/sub/and/or on two operands and queues
// {result, zero, rd, illegal} in a 2-entry FIFO behind a valid/ready handshake.
// The head entry is kept in a dedicated register so every output is a flop.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     upstream offers an operation
//   in_ready     operation accepted this cycle (registered, count < 2)
//   alu_control  4-bit operation code
//   op_a, op_b   WIDTH-bit operands
//   rd_in        destination tag, passed through unchanged
//   flush        discard all buffered and incoming operations
//   out_valid    head result presented (registered, count != 0)
//   out_ready    downstream consumes head result
//   result       head result
//   zero         head result == 0
//   rd_out       head destination tag
//   illegal      head operation carried an unsupported code
// ---------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAGW-1:0]  rd_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [TAGW-1:0]  rd_out,
    output logic             illegal
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNTW  = 2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic [TAGW-1:0]  rd;
        logic             illegal;
    } entry_t;

    entry_t            r_mem [DEPTH];
    entry_t            r_head;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [CNTW-1:0]   r_count;
    logic              r_out_valid;
    logic              r_in_ready;

    entry_t            w_entry;
    entry_t            w_head_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_wr_nxt;
    logic              w_rd_nxt;
    logic [CNTW-1:0]   w_count_nxt;

    // Operand -> ALU -> FIFO write data (the only combinational path)
    always_comb begin
        w_entry         = '0;
        w_entry.rd      = rd_in;
        case (alu_control)
            OP_ADD:  w_entry.result = op_a + op_b;
            OP_SUB:  w_entry.result = op_a - op_b;
            OP_AND:  w_entry.result = op_a & op_b;
            OP_OR:   w_entry.result = op_a | op_b;
            default: begin
                w_entry.result  = op_a + op_b;
                w_entry.illegal = 1'b1;
            end
        endcase
        w_entry.zero = (w_entry.result == '0);
    end

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;

    // FIFO next-state; flush overrides any accept in the same cycle
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_nxt    = r_wr_ptr;
        w_rd_nxt    = r_rd_ptr;
        w_count_nxt = r_count;
        if (flush) begin
            w_wr_nxt    = 1'b0;
            w_rd_nxt    = 1'b0;
            w_count_nxt = '0;
        end else begin
            if (w_push) begin
                w_wr_en  = 1'b1;
                w_wr_nxt = ~r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_nxt = ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNTW'(1);
                2'b01:   w_count_nxt = r_count - CNTW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Next head: bypass the write data when it lands in the next head slot
    always_comb begin
        if (w_wr_en && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = w_entry;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // Storage, pointers, count and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head      <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_entry;
            end
            r_wr_ptr    <= w_wr_nxt;
            r_rd_ptr    <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            r_in_ready  <= (w_count_nxt < CNTW'(DEPTH));
            // Hold last presented values while empty
            if (w_count_nxt != '0) begin
                r_head <= w_head_nxt;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_head.result;
    assign zero      = r_head.zero;
    assign rd_out    = r_head.rd;
    assign illegal   = r_head.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
// Directed bench with a scoreboard queue: expected entries are pushed when an
// operation is accepted and popped/compared when the DUT hands one downstream.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned TAGW  = 5;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic [TAGW-1:0]  rd;
        logic             illegal;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [TAGW-1:0]  rd_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [TAGW-1:0]  rd_out;
    logic             illegal;

    exp_t sb[$];
    int   checks;
    int   failures;
    bit   last_acc;

    alu_exec_stage #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .rd_in       (rd_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .rd_out      (rd_out),
        .illegal     (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic [TAGW-1:0] rd);
        exp_t e;
        e.rd      = rd;
        e.illegal = 1'b0;
        if (c == 4'b1000)      e.result = a - b;
        else if (c == 4'b0111) e.result = a & b;
        else if (c == 4'b0110) e.result = a | b;
        else begin
            e.result  = a + b;
            e.illegal = (c != 4'b0000);
        end
        e.zero = (e.result == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check flags against model occupancy, score a consume, record an accept
    task automatic step();
        exp_t e;
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        last_acc = 1'b0;
        if (out_valid === 1'b1 && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("result", result, e.result);
            chk("zero", 64'(zero), 64'(e.zero));
            chk("rd_out", 64'(rd_out), 64'(e.rd));
            chk("illegal", 64'(illegal), 64'(e.illegal));
        end
        if (in_valid && in_ready === 1'b1 && !flush && !reset) begin
            sb.push_back(model(alu_control, op_a, op_b, rd_in));
            last_acc = 1'b1;
        end
        if (flush || reset) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] c, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAGW-1:0] rd);
        int n;
        in_valid    = 1'b1;
        alu_control = c;
        op_a        = a;
        op_b        = b;
        rd_in       = rd;
        last_acc    = 1'b0;
        n           = 0;
        while (!last_acc && n < 20) begin
            step();
            n++;
        end
        chk("offer_accepted", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n         = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drained", 64'(sb.size()), 64'd0);
        step();
    endtask

    task automatic chk_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_rd_out", 64'(rd_out), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        alu_control = 4'b0000;
        op_a        = '0;
        op_b        = '0;
        rd_in       = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_reset();
        reset = 1'b0;

        // Add wrap: presented one cycle after accept
        out_ready = 1'b0;
        offer(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7);
        chk("wrap_valid", 64'(out_valid), 64'd1);
        chk("wrap_result", result, 64'd0);
        chk("wrap_zero", 64'(zero), 64'd1);
        chk("wrap_rd", 64'(rd_out), 64'd7);
        chk("wrap_illegal", 64'(illegal), 64'd0);
        drain();

        // Sub / and / or / sub-to-zero / illegal code
        out_ready = 1'b1;
        offer(4'b1000, 64'd5, 64'd3, 5'd1);
        offer(4'b0111, 64'hF0F0, 64'h0FF0, 5'd2);
        offer(4'b0110, 64'hF000, 64'h000F, 5'd3);
        offer(4'b1000, 64'h1234, 64'h1234, 5'd4);
        offer(4'b0011, 64'd2, 64'd3, 5'd5);
        chk("illegal_result", result, 64'd5);
        chk("illegal_flag", 64'(illegal), 64'd1);
        drain();

        // Back-pressure: third op waits until count drops below 2
        out_ready = 1'b0;
        offer(4'b0000, 64'd10, 64'd1, 5'd1);
        offer(4'b0000, 64'd20, 64'd2, 5'd2);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        in_valid    = 1'b1;
        alu_control = 4'b0000;
        op_a        = 64'd30;
        op_b        = 64'd3;
        rd_in       = 5'd3;
        step();
        chk("bp_tag3_held", 64'(last_acc), 64'd0);
        step();
        chk("bp_tag3_held2", 64'(last_acc), 64'd0);
        out_ready = 1'b1;
        offer(4'b0000, 64'd30, 64'd3, 5'd3);
        drain();

        // Streaming: one op per cycle with downstream always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            alu_control = (i % 2 == 0) ? 4'b0000 : 4'b1000;
            op_a        = 64'(i * 1000 + 7);
            op_b        = 64'(i * 3);
            rd_in       = TAGW'(i + 8);
            step();
            chk("stream_accept", 64'(last_acc), 64'd1);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        drain();

        // Flush with one entry and an acceptable incoming op: both dropped
        out_ready = 1'b0;
        offer(4'b0000, 64'd1, 64'd1, 5'd10);
        in_valid = 1'b1;
        rd_in    = 5'd11;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush1_empty", 64'(out_valid), 64'd0);
        step();

        // Flush with two entries while the head is consumed
        out_ready = 1'b0;
        offer(4'b0110, 64'h10, 64'h01, 5'd12);
        offer(4'b0111, 64'hFF, 64'h0F, 5'd13);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rd_in     = 5'd14;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush2_empty", 64'(out_valid), 64'd0);
        chk("flush2_in_ready", 64'(in_ready), 64'd1);
        step();

        // Reset mid-stream
        out_ready = 1'b0;
        offer(4'b0000, 64'h55, 64'h22, 5'd15);
        offer(4'b1000, 64'h99, 64'h11, 5'd16);
        reset    = 1'b1;
        in_valid = 1'b1;
        step();
        chk_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        step();

        // Operation resumes after reset
        out_ready = 1'b1;
        offer(4'b0000, 64'd40, 64'd2, 5'd17);
        chk("resume_result", result, 64'd42);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
